output_channel_scheduler: RTL and testbench
===========================================

// Module: output_channel_scheduler
// PURPOSE
//  Packet-level scheduler for one router output channel. Shares the channel among
//  N_REQ input channels with round-robin priority. Once a head flit wins, the grant
//  is locked to that input until its tail flit passes, so multi-flit packets are
//  never interleaved. A watchdog releases a lock whose owner stops supplying flits.
//  Orphan body flits are flagged for discard.
//  Sits between the per-input routing-table requests and the crossbar select,
//  one instance per output direction.
// PARAMETERS
//  N_REQ    4   number of requesting input channels (excludes the output's own input)
//  TIMEOUT  16  owner-starvation cycles before a lock is forcibly released (>=2)
//  CNT_W    5   stall counter width; must hold TIMEOUT
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  req          in   N_REQ  input i has a flit routed to this output (FIFO not empty)
//  head         in   N_REQ  flit at input i is a head flit (from HDR field)
//  tail         in   N_REQ  flit at input i is a tail flit; head&tail means a single-flit packet
//  busy         in   1      downstream channel cannot accept a flit this cycle
//  gnt          out  N_REQ  one-hot, combinational; flit i transfers this cycle (drives read/ena)
//  drop         out  N_REQ  combinational; input i must discard its orphan body flit this cycle
//  locked       out  1      registered; a multi-flit packet owns the channel
//  owner        out  2      registered; index of the lock holder (valid when locked)
//  timeout_evt  out  1      registered 1-cycle pulse; lock was force-released
// BEHAVIOUR
//  Reset (reset==0, async)
//   - state=IDLE, ptr=0, owner=0, cnt=0, locked=0, timeout_evt=0.
//   - gnt and drop are forced to 0 while reset==0.
//  Transfer
//   - A transfer occurs in any cycle where gnt[i]==1.
//   - gnt is never asserted while busy==1.
//   - At most one gnt bit is high at a time.
//  State IDLE
//   - Candidates = req & head.
//   - If busy==0 and any candidate: gnt = first candidate searching ptr, ptr+1, ... mod N_REQ.
//   - Winner w with tail[w]==1: stay IDLE; ptr <= w+1 mod N_REQ.
//   - Winner w with tail[w]==0: go to LOCKED; owner <= w; locked <= 1; cnt <= 0.
//   - drop[i] = req[i] & ~head[i], independent of busy. A body flit arriving with no
//     lock is an orphan; its input pops it. drop and gnt are never high for the same i.
//  State LOCKED
//   - gnt[owner] = req[owner] & ~busy. All other inputs get no gnt and no drop;
//     they simply wait.
//   - A head flit at the owner while LOCKED is a protocol error. It is still
//     transferred and terminates the lock as if it were a tail.
//   - Transfer with tail[owner]==1: go to IDLE; locked <= 0; ptr <= owner+1 mod N_REQ.
//   - cnt rules:
//       - Reset to 0 on every transfer.
//       - Incremented when req[owner]==0.
//       - Held when req[owner]==1 && busy==1. Backpressure never times out.
//   - When cnt==TIMEOUT-1 and increments: go to IDLE; locked <= 0;
//     ptr <= owner+1 mod N_REQ; timeout_evt <= 1 for exactly one cycle.
//     The owner's remaining flits become orphans and are dropped.
//  Other rules
//   - ptr wraps N_REQ-1 -> 0.
//   - Priority is only updated on packet completion or timeout, never per flit.
//   - Mid-operation reset drops any lock immediately. No partial state survives.
// TESTING
//  T1 reset=0 with req=4'b1111, head=4'b1111
//     -> gnt=0, drop=0, locked=0.
//     Release reset -> gnt=4'b0001 on the first cycle.
//  T2 all inputs hold single-flit packets (head=tail=1111), busy=0, 8 cycles
//     -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
//  T3 input 2 sends a 3-flit packet (H,B,T) while input 0 continuously requests with head
//     -> gnt=0100 for 3 transfer cycles; locked=1 and owner=2 after the head;
//        next grant=1000 if requesting, else 0001.
//  T4 inside T3, busy=1 for 30 cycles mid-packet
//     -> gnt=0, no timeout_evt; lock resumes on input 2 when busy=0.
//  T5 owner 1 stops after its head (req[1]=0), TIMEOUT=16
//     -> timeout_evt=1 exactly 16 cycles after the head transfer; locked=0.
//        A later body flit on input 1 gives drop=0010.
//  T6 IDLE with req=0011, head=0001
//     -> gnt=0001 and drop=0010 in the same cycle.
//        Same cycle with busy=1 -> gnt=0, drop=0010.

Source files
------------

// File: rtl/output_channel_scheduler.sv
// Round-robin packet scheduler for one router output channel: locks the grant to a
// packet's owner from head to tail, drops orphan body flits, and times out stalled owners.
module output_channel_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5,
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] head,
  input  logic [N_REQ-1:0] tail,
  input  logic             busy,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] drop,
  output logic             locked,
  output logic [IDX_W-1:0] owner,
  output logic             timeout_evt
);

  // Handshake: gnt[i] is the only transfer qualifier; it is never raised while busy is
  // high, so a flit moves exactly in the cycles where gnt[i]==1 and the input pops it.

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             locked_q;
  logic             tevt_q;

  logic [N_REQ-1:0] cand;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic             own_req;
  logic             own_xfer;
  logic             own_end;
  logic             cnt_expire;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Rotating search starting at ptr_q; the first candidate found wins.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    cand    = req & head;
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N_REQ)) sum = sum - (IDX_W + 1)'(N_REQ);
      idx = sum[IDX_W-1:0];
      if (!win_vld && cand[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  assign own_req    = req[owner_q];
  assign own_xfer   = (state_q == S_LOCKED) && own_req && !busy;
  // A head seen at the owner mid-packet is a protocol error; it still closes the packet.
  assign own_end    = tail[owner_q] | head[owner_q];
  assign cnt_d      = cnt_q + 1'b1;
  assign cnt_expire = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    gnt  = '0;
    drop = '0;
    if (reset) begin
      if (state_q == S_IDLE) begin
        drop = req & ~head;
        if (!busy && win_vld) gnt[win_idx] = 1'b1;
      end else if (own_xfer) begin
        gnt[owner_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      tevt_q   <= 1'b0;
    end else begin
      tevt_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!busy && win_vld) begin
            if (tail[win_idx]) begin
              ptr_q <= inc_idx(win_idx);
            end else begin
              state_q  <= S_LOCKED;
              owner_q  <= win_idx;
              locked_q <= 1'b1;
              cnt_q    <= '0;
            end
          end
        end
        S_LOCKED: begin
          if (own_xfer) begin
            cnt_q <= '0;
            if (own_end) begin
              state_q  <= S_IDLE;
              locked_q <= 1'b0;
              ptr_q    <= inc_idx(owner_q);
            end
          end else if (!own_req) begin
            if (cnt_expire) begin
              state_q  <= S_IDLE;
              locked_q <= 1'b0;
              ptr_q    <= inc_idx(owner_q);
              tevt_q   <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          // Owner present but backpressured: counter holds, lock never times out.
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign locked      = locked_q;
  assign owner       = owner_q;
  assign timeout_evt = tevt_q;

endmodule

// File: tb/tb_output_channel_scheduler.sv
// Directed and randomized bench for output_channel_scheduler against a packet-level
// reference model held in plain integers.
module tb_output_channel_scheduler;

  localparam int N       = 4;
  localparam int TIMEOUT = 16;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] head;
  logic [N-1:0] tail;
  logic         busy;
  logic [N-1:0] gnt;
  logic [N-1:0] drop;
  logic         locked;
  logic [1:0]   owner;
  logic         timeout_evt;

  output_channel_scheduler #(.N_REQ(N), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .req(req), .head(head), .tail(tail), .busy(busy),
    .gnt(gnt), .drop(drop), .locked(locked), .owner(owner), .timeout_evt(timeout_evt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the channel, where priority starts, idle cycles of owner
  bit m_locked = 0;
  int m_owner  = 0;
  int m_ptr    = 0;
  int m_cnt    = 0;
  bit m_tevt   = 0;

  logic [N-1:0] g_last;
  logic [N-1:0] d_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then registered ones.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] h, input logic [N-1:0] t,
                      input logic b, input logic rn);
    logic [N-1:0] eg;
    logic [N-1:0] ed;
    bit found;
    int w;
    @(negedge clk);
    req = r; head = h; tail = t; busy = b; reset = rn;
    #1;
    eg = '0; ed = '0; found = 0; w = 0;
    if (!rn) begin
      m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_tevt = 0;
    end else if (!m_locked) begin
      ed = r & ~h;
      if (!b) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (!found && r[i] && h[i]) begin
            found = 1;
            w = i;
          end
        end
      end
      if (found) eg[w] = 1'b1;
    end else if (r[m_owner] && !b) begin
      eg[m_owner] = 1'b1;
    end
    g_last = gnt;
    d_last = drop;
    check("gnt", 32'(gnt), 32'(eg));
    check("drop", 32'(drop), 32'(ed));
    @(posedge clk);
    #1;
    if (rn) begin
      m_tevt = 0;
      if (!m_locked) begin
        if (found) begin
          if (t[w]) m_ptr = (w + 1) % N;
          else begin
            m_locked = 1; m_owner = w; m_cnt = 0;
          end
        end
      end else if (r[m_owner] && !b) begin
        m_cnt = 0;
        if (t[m_owner] || h[m_owner]) begin
          m_locked = 0; m_ptr = (m_owner + 1) % N;
        end
      end else if (!r[m_owner]) begin
        m_cnt++;
        if (m_cnt == TIMEOUT) begin
          m_locked = 0; m_ptr = (m_owner + 1) % N; m_tevt = 1; m_cnt = 0;
        end
      end
    end
    check("locked", 32'(locked), 32'(m_locked));
    check("timeout_evt", 32'(timeout_evt), 32'(m_tevt));
    if (m_locked) check("owner", 32'(owner), 32'(m_owner));
  endtask

  logic [N-1:0] t2_seq [8];
  logic [N-1:0] t2_exp [8];
  int n_to;
  int tevt_seen;

  initial begin
    t2_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // T1: reset holds everything quiet even with every input requesting heads
    reset = 1'b0; req = 4'b1111; head = 4'b1111; tail = 4'b1111; busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t1_gnt_in_reset", 32'(gnt), 32'h0);
    check("t1_drop_in_reset", 32'(drop), 32'h0);
    check("t1_locked_in_reset", 32'(locked), 32'h0);

    // T1/T2: release reset, single-flit packets rotate through all inputs
    for (int c = 0; c < 8; c++) begin
      step(4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b1);
      t2_seq[c] = g_last;
    end
    for (int c = 0; c < 8; c++) check($sformatf("t2_seq%0d", c), 32'(t2_seq[c]), 32'(t2_exp[c]));

    // T3: advance priority past input 0, then input 2 sends H,B,T with input 0 waiting
    step(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1);
    step(4'b0101, 4'b0101, 4'b0001, 1'b0, 1'b1);
    check("t3_head_gnt", 32'(g_last), 32'h4);
    check("t3_locked", 32'(locked), 32'h1);
    check("t3_owner", 32'(owner), 32'h2);
    step(4'b0101, 4'b0001, 4'b0001, 1'b0, 1'b1);
    check("t3_body_gnt", 32'(g_last), 32'h4);

    // T4: long backpressure mid-packet never times out
    tevt_seen = 0;
    for (int c = 0; c < 30; c++) begin
      step(4'b0101, 4'b0001, 4'b0101, 1'b1, 1'b1);
      if (timeout_evt) tevt_seen++;
    end
    check("t4_no_timeout", 32'(tevt_seen), 32'h0);
    check("t4_still_locked", 32'(locked), 32'h1);
    step(4'b0101, 4'b0001, 4'b0101, 1'b0, 1'b1);
    check("t4_tail_gnt", 32'(g_last), 32'h4);
    check("t4_unlocked", 32'(locked), 32'h0);
    step(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b1);
    check("t3_next_gnt", 32'(g_last), 32'h1);

    // T5: owner 1 goes silent after its head
    step(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1);
    check("t5_owner", 32'(owner), 32'h1);
    n_to = 41;
    for (int c = 1; c <= 40; c++) begin
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
      if (timeout_evt) begin
        n_to = c;
        break;
      end
    end
    check("t5_timeout_cycles", 32'(n_to), 32'(TIMEOUT));
    check("t5_unlocked", 32'(locked), 32'h0);
    step(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1);
    check("t5_orphan_drop", 32'(d_last), 32'h2);
    check("t5_pulse_gone", 32'(timeout_evt), 32'h0);

    // T6: grant and drop together, then busy suppresses only the grant
    step(4'b0011, 4'b0001, 4'b0001, 1'b0, 1'b1);
    check("t6_gnt", 32'(g_last), 32'h1);
    check("t6_drop", 32'(d_last), 32'h2);
    step(4'b0011, 4'b0001, 4'b0001, 1'b1, 1'b1);
    check("t6_busy_gnt", 32'(g_last), 32'h0);
    check("t6_busy_drop", 32'(d_last), 32'h2);

    // Randomized traffic with a mid-run reset and quiet stretches to exercise timeouts
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] r;
      logic [N-1:0] h;
      logic [N-1:0] t;
      logic b;
      r = N'($urandom);
      h = N'($urandom);
      t = N'($urandom);
      b = ($urandom_range(0, 3) == 0);
      if (c >= 350 && c < 450 && $urandom_range(0, 4) != 0) r = '0;
      step(r, h, t, b, !(c == 200 || c == 201));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: observed=hang expected=finish");
    $fatal(1, "timeout");
  end

endmodule
